time_keeper: RTL and testbench
==============================

# time_keeper

Time-keeping and setting engine for the alarm clock: divides the system clock to a 1 Hz tick, runs the 24-hour wall clock, and stores the alarm time. Button presses walk a mode state machine for setting clock and alarm fields. Outputs are binary hour/minute/second values that drive the display/compare stage, which converts them to BCD digits and raises the alarm flag.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per 1 Hz tick; must be ≥ 2.
- `IDLE_SECS`, default 30: ticks without a button press before a set mode falls back to RUN.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock domain; reset is synchronous and active-high.
- `btn`  in  4  raw, already-debounced buttons: [0] mode, [1] increment, [2] decrement, [3] unused.
- `c_hour`  out  6  clock hours, 0–23.
- `c_min`  out  6  clock minutes, 0–59.
- `c_sec`  out  6  clock seconds, 0–59.
- `a_hr`  out  6  alarm hours, 0–23.
- `a_min`  out  6  alarm minutes, 0–59.
- `mode`  out  3  current state encoding, for display blinking.
- `tick`  out  1  one-cycle 1 Hz strobe.

## Operation
- Button pulse: `btn[i]` is 1 at a clk edge and its previously sampled value is 0. The previously-sampled register resets to 1, so a button held through reset produces no pulse.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick`=1 while the count equals TICK_DIV-1.
- States: RUN=0, SET_CLK_HR=1, SET_CLK_MIN=2, SET_ALM_HR=3, SET_ALM_MIN=4. Values 5–7 are illegal and recover to RUN on the next edge.
- Mode pulse advances RUN→1→2→3→4→RUN.
- RUN: on tick, increment `c_sec`. At 59, `c_sec` goes to 0 and carries into `c_min`. At 59, `c_min` goes to 0 and carries into `c_hour`. `c_hour` wraps 23→0. 23:59:59 becomes 00:00:00 in one edge.
- SET_CLK_HR, SET_CLK_MIN:
  - `c_sec` is forced to 0 on entry into SET_CLK_HR and held there.
  - No tick counting occurs in these states.
  - inc/dec affects only the selected field: hr wraps 23↔0, min wraps 59↔0, with no carry between fields.
- SET_ALM_HR, SET_ALM_MIN:
  - inc/dec the selected alarm field, with the same wrap rules.
  - The clock keeps running as in RUN.
- Simultaneous pulses:
  - A mode pulse wins; any inc/dec in the same cycle is ignored.
  - inc and dec together are both ignored.
- Idle timeout:
  - In any set state, an idle counter counts ticks and clears on any button pulse.
  - When it reaches IDLE_SECS, the state goes to RUN.
- Leaving SET_CLK_MIN or SET_CLK_HR for RUN, by mode pulse or timeout, clears the prescaler to 0. The first second after setting is therefore a full TICK_DIV cycles.
- Reset values:
  - `mode`=RUN.
  - `c_hour`/`c_min`/`c_sec`=0.
  - `a_hr`=7, `a_min`=0.
  - Prescaler and idle counter = 0.
  - `tick`=0.

## Timing
- All outputs are registered except `tick`, which decodes the prescaler combinationally.
- Button press to field/mode change: visible after the first edge at which the pulse condition holds, i.e. one cycle of latency.
- Tick to `c_sec` change: visible after the edge where `tick`=1.
- A carry chain resolves within that same edge; no multi-cycle ripple.
- Reset mid-set-mode: the next edge gives RUN and reset values. Alarm values are lost.
- The prescaler never stalls except for the clear on SET_CLK exit.
- Width rule: all comparisons use 6-bit values against constants. Fields are never written with values above their maximum.

## Structure
- Package `time_pkg`:
  - mode state localparams (RUN..SET_ALM_MIN).
  - `MAX_HR`=23, `MAX_MIN`=59, `MAX_SEC`=59.
  - reset defaults `ALM_HR_RST`=7, `ALM_MIN_RST`=0.
- Sub-module `btn_pulse`: one per button, 1-bit rising-edge pulse generator with synchronous reset to "previously high".
- Top module holds the prescaler, FSM, counters and a shared wrap-increment/decrement helper function.

## Test plan
All scenarios use TICK_DIV=4, IDLE_SECS=3.
- Reset, then run 240 cycles → `c_sec` reaches 59 then 0, `c_min`=1; `tick` pulses every 4th cycle; `a_hr`=7.
- Force time to 23:59:59 via set modes, return to RUN, wait 4 cycles → 00:00:00 in a single edge.
- Mode pulse once, then dec pulse at `c_hour`=0 → `c_hour`=23, `c_sec`=0 and frozen. Mode pulse, then inc at `c_min`=59 → `c_min`=0 and `c_hour` unchanged.
- In SET_ALM_MIN, press inc+dec in the same cycle → `a_min` unchanged. Press mode+inc in the same cycle → `mode`=RUN and `a_min` unchanged.
- Enter SET_ALM_HR, no buttons for 3 ticks (12 cycles) → `mode`=RUN. A button pressed at tick 2 restarts the count.
- Hold `btn[0]` high through reset release → no mode change. Assert reset in SET_CLK_MIN → `mode`=0 and all fields at reset values on the next edge.

Source files
------------

// File: rtl/time_pkg.sv
// time_pkg: shared mode encoding, field limits and reset defaults for the alarm clock.
package time_pkg;
  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_CLK_HR  = 3'd1,
    SET_CLK_MIN = 3'd2,
    SET_ALM_HR  = 3'd3,
    SET_ALM_MIN = 3'd4
  } mode_t;
  localparam logic [5:0] MAX_HR      = 6'd23;
  localparam logic [5:0] MAX_MIN     = 6'd59;
  localparam logic [5:0] MAX_SEC     = 6'd59;
  localparam logic [5:0] ALM_HR_RST  = 6'd7;
  localparam logic [5:0] ALM_MIN_RST = 6'd0;
endpackage

// File: rtl/btn_pulse.sv
// btn_pulse: rising-edge detector; resets to "previously high" so a held button is ignored.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic prev_q;
  always_ff @(posedge clk)
    if (rst) prev_q <= 1'b1;
    else prev_q <= d;
  assign pulse = d & ~prev_q;
endmodule

// File: rtl/time_keeper.sv
// time_keeper: 1 Hz prescaler, 24 h wall clock, alarm storage and button-driven set-mode FSM.
module time_keeper
  import time_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int IDLE_SECS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [5:0] c_hour,
  output logic [5:0] c_min,
  output logic [5:0] c_sec,
  output logic [5:0] a_hr,
  output logic [5:0] a_min,
  output logic [2:0] mode,
  output logic       tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(IDLE_SECS + 1);
  function automatic logic [5:0] wrap(input logic [5:0] v, input logic [5:0] max, input logic up, input logic dn);
    return up ? (v == max ? 6'd0 : v + 6'd1) : dn ? (v == 6'd0 ? max : v - 6'd1) : v;
  endfunction
  logic [3:0] p;
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_pulse u_pulse (.clk(clk), .rst(rst), .d(btn[i]), .pulse(p[i]));
  end
  mode_t          state_q, state_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic [5:0]     c_hour_q, c_hour_d, c_min_q, c_min_d, c_sec_q, c_sec_d;
  logic [5:0]     a_hr_q, a_hr_d, a_min_q, a_min_d;
  logic           legal, set_any, clk_set, timeout, adj, up, dn, run_clk, sec_wrap, min_wrap;
  assign tick     = pre_q == PW'(TICK_DIV - 1);
  assign legal    = state_q <= SET_ALM_MIN;
  assign set_any  = legal && state_q != RUN;
  assign clk_set  = state_q == SET_CLK_HR || state_q == SET_CLK_MIN;
  assign timeout  = set_any && p == 4'd0 && tick && idle_q == IW'(IDLE_SECS - 1);
  assign adj      = set_any && !p[0] && (p[1] ^ p[2]);
  assign up       = adj && p[1];
  assign dn       = adj && p[2];
  // Entering SET_CLK_HR zeroes seconds, so that edge does no counting.
  assign run_clk  = tick && (state_q == RUN ? !p[0] : (state_q == SET_ALM_HR || state_q == SET_ALM_MIN));
  assign sec_wrap = c_sec_q == MAX_SEC;
  assign min_wrap = c_min_q == MAX_MIN;
  always_comb begin
    state_d  = !legal ? RUN : p[0] ? (state_q == SET_ALM_MIN ? RUN : mode_t'(state_q + 3'd1)) : timeout ? RUN : state_q;
    pre_d    = (clk_set && state_d == RUN) || tick ? '0 : pre_q + PW'(1);
    idle_d   = (state_d == RUN || |p) ? '0 : tick ? idle_q + IW'(1) : idle_q;
    c_sec_d  = (state_q == RUN && p[0]) ? 6'd0 : run_clk ? (sec_wrap ? 6'd0 : c_sec_q + 6'd1) : c_sec_q;
    c_min_d  = (run_clk && sec_wrap) ? wrap(c_min_q, MAX_MIN, 1'b1, 1'b0)
             : state_q == SET_CLK_MIN ? wrap(c_min_q, MAX_MIN, up, dn) : c_min_q;
    c_hour_d = (run_clk && sec_wrap && min_wrap) ? wrap(c_hour_q, MAX_HR, 1'b1, 1'b0)
             : state_q == SET_CLK_HR ? wrap(c_hour_q, MAX_HR, up, dn) : c_hour_q;
    a_hr_d   = state_q == SET_ALM_HR ? wrap(a_hr_q, MAX_HR, up, dn) : a_hr_q;
    a_min_d  = state_q == SET_ALM_MIN ? wrap(a_min_q, MAX_MIN, up, dn) : a_min_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= RUN;
      pre_q    <= '0;
      idle_q   <= '0;
      c_hour_q <= 6'd0;
      c_min_q  <= 6'd0;
      c_sec_q  <= 6'd0;
      a_hr_q   <= ALM_HR_RST;
      a_min_q  <= ALM_MIN_RST;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      idle_q   <= idle_d;
      c_hour_q <= c_hour_d;
      c_min_q  <= c_min_d;
      c_sec_q  <= c_sec_d;
      a_hr_q   <= a_hr_d;
      a_min_q  <= a_min_d;
    end
  assign c_hour = c_hour_q;
  assign c_min  = c_min_q;
  assign c_sec  = c_sec_q;
  assign a_hr   = a_hr_q;
  assign a_min  = a_min_q;
  assign mode   = state_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed table, corner sequences and random stimulus against a seconds-of-day model.
module tb_time_keeper;
  localparam int TD = 4;
  localparam int IS = 3;
  logic       clk, rst;
  logic [3:0] btn;
  logic [5:0] c_hour, c_min, c_sec, a_hr, a_min;
  logic [2:0] mode;
  logic       tick;
  time_keeper #(.TICK_DIV(TD), .IDLE_SECS(IS)) dut (
    .clk(clk), .rst(rst), .btn(btn), .c_hour(c_hour), .c_min(c_min), .c_sec(c_sec),
    .a_hr(a_hr), .a_min(a_min), .mode(mode), .tick(tick)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  int m_mode, m_t, m_ah, m_am, m_pc, m_idle;
  logic [3:0] m_prev;
  typedef struct {
    logic [3:0] b;
    logic [2:0] md;
    logic [5:0] h, m, s, ah, am;
  } vec_t;
  vec_t tbl[24];
  task automatic check(input string nm, input logic [33:0] got, input logic [33:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
    else passed++;
  endtask
  task automatic model(input bit r, input logic [3:0] b);
    logic [3:0] pl;
    bit tk, adj;
    int nm, h, mi, d;
    if (r) begin
      m_mode = 0; m_t = 0; m_ah = 7; m_am = 0; m_pc = 0; m_idle = 0; m_prev = 4'hf;
      return;
    end
    pl = b & ~m_prev;
    m_prev = b;
    tk = m_pc == TD - 1;
    nm = m_mode;
    if (pl[0]) nm = (m_mode + 1) % 5;
    else if (m_mode != 0 && pl == 4'd0 && tk && m_idle + 1 == IS) nm = 0;
    adj = m_mode != 0 && !pl[0] && (pl[1] != pl[2]);
    d = pl[1] ? 1 : -1;
    h = m_t / 3600;
    mi = (m_t / 60) % 60;
    if (m_mode == 0 && pl[0]) m_t = m_t - m_t % 60;
    else if (tk && (m_mode == 0 || m_mode >= 3)) m_t = (m_t + 1) % 86400;
    if (adj)
      case (m_mode)
        1: m_t = ((h + d + 24) % 24) * 3600 + m_t % 3600;
        2: m_t = h * 3600 + ((mi + d + 60) % 60) * 60 + m_t % 60;
        3: m_ah = (m_ah + d + 24) % 24;
        4: m_am = (m_am + d + 60) % 60;
        default: ;
      endcase
    m_pc = ((m_mode == 1 || m_mode == 2) && nm == 0) ? 0 : (m_pc + 1) % TD;
    m_idle = (nm == 0 || pl != 4'd0) ? 0 : tk ? m_idle + 1 : m_idle;
    m_mode = nm;
  endtask
  function automatic logic [33:0] model_vec();
    return {3'(m_mode), 6'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 6'(m_ah), 6'(m_am), m_pc == TD - 1};
  endfunction
  task automatic step(input bit r, input logic [3:0] b);
    rst = r;
    btn = b;
    model(r, b);
    @(posedge clk);
    #1;
    check("model", {mode, c_hour, c_min, c_sec, a_hr, a_min, tick}, model_vec());
  endtask
  task automatic hms(input string nm, input int h, input int m, input int s);
    check(nm, {16'd0, c_hour, c_min, c_sec}, {16'd0, 6'(h), 6'(m), 6'(s)});
  endtask
  initial begin
    tbl[0]  = '{4'd0, 3'd0, 6'd0,  6'd0,  6'd0, 6'd7, 6'd0};
    tbl[1]  = '{4'd1, 3'd1, 6'd0,  6'd0,  6'd0, 6'd7, 6'd0};
    tbl[2]  = '{4'd0, 3'd1, 6'd0,  6'd0,  6'd0, 6'd7, 6'd0};
    tbl[3]  = '{4'd4, 3'd1, 6'd23, 6'd0,  6'd0, 6'd7, 6'd0};
    tbl[4]  = '{4'd0, 3'd1, 6'd23, 6'd0,  6'd0, 6'd7, 6'd0};
    tbl[5]  = '{4'd1, 3'd2, 6'd23, 6'd0,  6'd0, 6'd7, 6'd0};
    tbl[6]  = '{4'd0, 3'd2, 6'd23, 6'd0,  6'd0, 6'd7, 6'd0};
    tbl[7]  = '{4'd4, 3'd2, 6'd23, 6'd59, 6'd0, 6'd7, 6'd0};
    tbl[8]  = '{4'd0, 3'd2, 6'd23, 6'd59, 6'd0, 6'd7, 6'd0};
    tbl[9]  = '{4'd2, 3'd2, 6'd23, 6'd0,  6'd0, 6'd7, 6'd0};
    tbl[10] = '{4'd0, 3'd2, 6'd23, 6'd0,  6'd0, 6'd7, 6'd0};
    tbl[11] = '{4'd4, 3'd2, 6'd23, 6'd59, 6'd0, 6'd7, 6'd0};
    tbl[12] = '{4'd0, 3'd2, 6'd23, 6'd59, 6'd0, 6'd7, 6'd0};
    tbl[13] = '{4'd1, 3'd3, 6'd23, 6'd59, 6'd0, 6'd7, 6'd0};
    tbl[14] = '{4'd0, 3'd3, 6'd23, 6'd59, 6'd0, 6'd7, 6'd0};
    tbl[15] = '{4'd2, 3'd3, 6'd23, 6'd59, 6'd1, 6'd8, 6'd0};
    tbl[16] = '{4'd0, 3'd3, 6'd23, 6'd59, 6'd1, 6'd8, 6'd0};
    tbl[17] = '{4'd1, 3'd4, 6'd23, 6'd59, 6'd1, 6'd8, 6'd0};
    tbl[18] = '{4'd0, 3'd4, 6'd23, 6'd59, 6'd1, 6'd8, 6'd0};
    tbl[19] = '{4'd6, 3'd4, 6'd23, 6'd59, 6'd2, 6'd8, 6'd0};
    tbl[20] = '{4'd0, 3'd4, 6'd23, 6'd59, 6'd2, 6'd8, 6'd0};
    tbl[21] = '{4'd4, 3'd4, 6'd23, 6'd59, 6'd2, 6'd8, 6'd59};
    tbl[22] = '{4'd0, 3'd4, 6'd23, 6'd59, 6'd2, 6'd8, 6'd59};
    tbl[23] = '{4'd3, 3'd0, 6'd23, 6'd59, 6'd3, 6'd8, 6'd59};
    rst = 1'b1;
    btn = 4'd0;
    // free run from reset: 60 ticks in 240 cycles
    step(1, 0); step(1, 0);
    check("reset", {mode, c_hour, c_min, c_sec, a_hr, a_min, tick}, {3'd0, 6'd0, 6'd0, 6'd0, 6'd7, 6'd0, 1'b0});
    for (int i = 1; i <= 240; i++) begin
      step(0, 0);
      if (i % 4 == 3) check("tick_phase", {33'd0, tick}, 34'd1);
      if (i == 236) hms("sec59", 0, 0, 59);
    end
    hms("one_min", 0, 1, 0);
    check("alarm_rst", {28'd0, a_hr}, 34'd7);
    // directed set-mode table
    step(1, 0); step(1, 0);
    foreach (tbl[i]) begin
      step(0, tbl[i].b);
      check($sformatf("tbl%0d", i), {mode, c_hour, c_min, c_sec, a_hr, a_min, 1'b0},
            {tbl[i].md, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].ah, tbl[i].am, 1'b0});
    end
    // midnight rollover in a single edge
    repeat (224) step(0, 0);
    hms("pre_midnight", 23, 59, 59);
    repeat (3) step(0, 0);
    hms("hold_59", 23, 59, 59);
    step(0, 0);
    hms("midnight", 0, 0, 0);
    // idle timeout out of SET_ALM_HR
    step(0, 1); step(0, 0); step(0, 1); step(0, 0); step(0, 1);
    check("alm_hr_mode", {31'd0, mode}, 34'd3);
    repeat (8) step(0, 0);
    check("idle_2ticks", {31'd0, mode}, 34'd3);
    repeat (4) step(0, 0);
    check("idle_timeout", {31'd0, mode}, 34'd0);
    // a press inside the window restarts the idle count
    step(0, 1); step(0, 0); step(0, 1); step(0, 0); step(0, 1);
    repeat (6) step(0, 0);
    step(0, 2);
    repeat (8) step(0, 0);
    check("idle_restart", {31'd0, mode}, 34'd3);
    repeat (4) step(0, 0);
    check("idle_restart_to", {31'd0, mode}, 34'd0);
    // mode held through reset release gives no pulse
    step(1, 1); step(1, 1); step(0, 1); step(0, 1);
    check("held_mode", {31'd0, mode}, 34'd0);
    step(0, 0);
    // reset inside SET_CLK_MIN
    step(0, 1); step(0, 0); step(0, 1); step(0, 0); step(0, 2); step(0, 0);
    check("in_set_min", {31'd0, mode}, 34'd2);
    step(1, 0);
    check("reset_mid_set", {mode, c_hour, c_min, c_sec, a_hr, a_min, tick}, {3'd0, 6'd0, 6'd0, 6'd0, 6'd7, 6'd0, 1'b0});
    // random presses against the model
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 499) == 0, ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
